memory_access_ctrl: RTL and testbench

// - Parametrised memory-stage access controller for the ARM32 pipeline, sitting between execute and writeback.
// - Turns decoded LDR/STR into a held request/ack transaction on the data-memory port, stalling upstream until done.
// - Squashes wrong-path memory ops by comparing the instruction's branch tag with the global branch reference.
// - Returns load data to writeback with its destination register.

---
 rtl/memory_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_memory_access_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_ctrl.sv
// Memory-stage LDR/STR access controller: held req/ack bus cycle, wrong-path squash, load writeback.
// Optional bus timeout with bus_err pulse when MEM_TIMEOUT_EN is defined.
module memory_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              branch_tag_in,
  input  logic              branch_ref,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [3:0]        rd_in,
  output logic              ready_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [3:0]        rd_q, rd_d;
  logic [3:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              bus_err_q, bus_err_d;
  logic              accept;
  logic              on_path;
  logic              cnt_unused;

  assign accept  = valid_in && (state_q == IDLE);
  assign on_path = (branch_tag_in == branch_ref);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    bus_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && on_path && (is_load || is_store)) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
          rd_d    = rd_in;
          we_d    = is_store;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            wb_data_d = mem_rdata;
            wb_rd_d   = rd_q;
            state_d   = WB;
          end
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end
`endif
        end
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Request and writeback strobes decode straight from state so reset drops them at once
  assign ready_out = (state_q == IDLE);
  assign stall     = valid_in && !ready_out;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = (state_q == WB);
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

`ifdef MEM_TIMEOUT_EN
  assign bus_err    = bus_err_q;
  assign cnt_unused = 1'b0;
`else
  assign bus_err    = 1'b0;
  assign cnt_unused = ^{cnt_q, bus_err_q};
`endif

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Self-checking bench for memory_access_ctrl; load writebacks checked via a scoreboard queue.
module tb_memory_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        branch_tag_in = 1'b0;
  logic        branch_ref = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [3:0]  rd_in = '0;
  logic        ready_out, stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bus_err;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  wb_seen = 0;

  memory_access_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .is_load(is_load), .is_store(is_store),
    .branch_tag_in(branch_tag_in), .branch_ref(branch_ref),
    .addr_in(addr_in), .wdata_in(wdata_in), .rd_in(rd_in),
    .ready_out(ready_out), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      wb_t e;
      wb_seen++;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback",
                 wb_rd, wb_data);
      end else begin
        e = sb_q.pop_front();
        if ({wb_rd, wb_data} !== e) begin
          miscompares++;
          $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    valid_in = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ready_out, mem_req, mem_we, wb_valid, bus_err, stall} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy,req,we,wbv,err,stall=%b, required 100000",
               {ready_out, mem_req, mem_we, wb_valid, bus_err, stall});
    end
    vectors++;
    if ({mem_addr, mem_wdata, wb_rd, wb_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h wdata=%h rd=%0d data=%h, required all 0",
               mem_addr, mem_wdata, wb_rd, wb_data);
    end
    align();
    rst_n = 1'b1;
  endtask

  task automatic test_load_zero_wait();
    align();
    valid_in = 1; is_load = 1; addr_in = 32'h100; rd_in = 4'd3;
    @(negedge clk);
    vectors++;
    if (ready_out !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_accept: got ready=%b stall=%b, required 1 0", ready_out, stall);
    end
    align();
    clear_in();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    sb_q.push_back({4'd3, 32'hDEADBEEF});
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, ready_out} !== 3'b100 || mem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL t1_req: got req,we,rdy=%b addr=%h, required 100 addr=100",
               {mem_req, mem_we, ready_out}, mem_addr);
    end
    align();
    mem_ack = 0;
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 4'd3 || ready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_wb: got wbv=%b rd=%0d rdy=%b, required 1 3 0",
               wb_valid, wb_rd, ready_out);
    end
    align();
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || ready_out !== 1'b1 || wb_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL t1_after: got wbv=%b rdy=%b data=%h, required 0 1 deadbeef",
               wb_valid, ready_out, wb_data);
    end
  endtask

  task automatic test_store_wait();
    align();
    valid_in = 1; is_store = 1; addr_in = 32'h20; wdata_in = 32'h55;
    align();
    is_store = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) branch_ref = ~branch_ref;
      if (i == 3) mem_ack = 1;
      @(negedge clk);
      vectors++;
      if ({mem_req, mem_we, stall, ready_out} !== 4'b1110 ||
          mem_addr !== 32'h20 || mem_wdata !== 32'h55) begin
        miscompares++;
        $display("FAIL t2_hold%0d: got req,we,stall,rdy=%b addr=%h wd=%h, required 1110 20 55",
                 i, {mem_req, mem_we, stall, ready_out}, mem_addr, mem_wdata);
      end
      align();
    end
    mem_ack = 0;
    branch_ref = branch_tag_in;
    @(negedge clk);
    vectors++;
    if ({ready_out, stall, mem_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL t2_done: got rdy,stall,req=%b, required 100",
               {ready_out, stall, mem_req});
    end
    align();
    clear_in();
  endtask

  task automatic test_squash();
    align();
    valid_in = 1; is_load = 1; branch_tag_in = 0; branch_ref = 1;
    addr_in = 32'h300; rd_in = 4'd6;
    align();
    clear_in();
    branch_ref = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({mem_req, ready_out, wb_valid} !== 3'b010) begin
        miscompares++;
        $display("FAIL t3_squash%0d: got req,rdy,wbv=%b, required 010",
                 i, {mem_req, ready_out, wb_valid});
      end
      align();
    end
  endtask

  task automatic test_reset_in_req();
    align();
    valid_in = 1; is_load = 1; addr_in = 32'h44; rd_in = 4'd9;
    align();
    clear_in();
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_req: got req=%b, required 1", mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_async: got req=%b rdy=%b, required 0 1", mem_req, ready_out);
    end
    align();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({ready_out, mem_req, wb_valid} !== 3'b100) begin
        miscompares++;
        $display("FAIL t4_post%0d: got rdy,req,wbv=%b, required 100",
                 i, {ready_out, mem_req, wb_valid});
      end
      align();
    end
  endtask

  task automatic test_timeout();
    int wbs;
    align();
    valid_in = 1; is_load = 1; addr_in = 32'h80; rd_in = 4'd7;
    align();
    clear_in();
    wbs = wb_seen;
`ifdef MEM_TIMEOUT_EN
    begin
      int req_cyc = 0;
      int errs = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_req) req_cyc++;
        if (bus_err) errs++;
        align();
      end
      vectors++;
      if (errs !== 1) begin
        miscompares++;
        $display("FAIL t5_buserr: got %0d pulses, required 1", errs);
      end
      vectors++;
      if (req_cyc < TMO || req_cyc > TMO + 1) begin
        miscompares++;
        $display("FAIL t5_reqlen: got %0d req cycles, required %0d..%0d",
                 req_cyc, TMO, TMO + 1);
      end
      vectors++;
      if (mem_req !== 1'b0 || ready_out !== 1'b1 || wb_seen !== wbs) begin
        miscompares++;
        $display("FAIL t5_end: got req=%b rdy=%b wb=%0d, required 0 1 %0d",
                 mem_req, ready_out, wb_seen, wbs);
      end
    end
`else
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (mem_req !== 1'b1 || bus_err !== 1'b0 || mem_addr !== 32'h80) bad++;
        align();
      end
      vectors++;
      if (bad !== 0 || wb_seen !== wbs) begin
        miscompares++;
        $display("FAIL t5_hold: got %0d bad cycles wb=%0d, required 0 %0d",
                 bad, wb_seen, wbs);
      end
      mem_ack = 1; mem_rdata = 32'h12345678;
      sb_q.push_back({4'd7, 32'h12345678});
      align();
      mem_ack = 0;
      @(negedge clk);
      vectors++;
      if (wb_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL t5_lateack: got wbv=%b, required 1", wb_valid);
      end
      align();
    end
`endif
  endtask

  task automatic test_spurious();
    align();
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({mem_req, ready_out, wb_valid} !== 3'b010) begin
        miscompares++;
        $display("FAIL t6_ack%0d: got req,rdy,wbv=%b, required 010",
                 i, {mem_req, ready_out, wb_valid});
      end
      align();
    end
    mem_ack = 0;
    valid_in = 1; is_load = 0; is_store = 0; addr_in = 32'h999;
    align();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({mem_req, ready_out, wb_valid} !== 3'b010 || mem_addr === 32'h999) begin
        miscompares++;
        $display("FAIL t6_alu%0d: got req,rdy,wbv=%b addr=%h, required 010 addr!=999",
                 i, {mem_req, ready_out, wb_valid}, mem_addr);
      end
      align();
    end
  endtask

  task automatic drive_op(input bit ld, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] r);
    valid_in = 1; is_load = ld; is_store = !ld;
    addr_in = a; wdata_in = wd; rd_in = r;
  endtask

  task automatic test_back_to_back();
    bit          ld[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] ad[3] = '{32'h40, 32'h44, 32'h48};
    logic [31:0] wd[3] = '{32'h0, 32'hCAFE, 32'h0};
    logic [3:0]  rr[3] = '{4'd5, 4'd0, 4'd12};
    logic [31:0] rv[3] = '{32'hA5A5_0001, 32'h0, 32'h5A5A_0002};
    align();
    drive_op(ld[0], ad[0], wd[0], rr[0]);
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      @(negedge clk);
      while (!ready_out && n < 10) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (ready_out !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready%0d: got rdy=%b, required 1 within 10 cycles",
                 k, ready_out);
      end
      align();
      mem_ack = 1; mem_rdata = rv[k];
      if (ld[k]) sb_q.push_back({rr[k], rv[k]});
      if (k < 2) drive_op(ld[k+1], ad[k+1], wd[k+1], rr[k+1]);
      else clear_in();
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b1 || mem_we !== !ld[k] || mem_addr !== ad[k] ||
          (!ld[k] && mem_wdata !== wd[k]) || stall !== (k < 2)) begin
        miscompares++;
        $display("FAIL b2b_req%0d: got req=%b we=%b addr=%h wd=%h stall=%b, required 1 %b %h %h %b",
                 k, mem_req, mem_we, mem_addr, mem_wdata, stall,
                 !ld[k], ad[k], wd[k], k < 2);
      end
      align();
      mem_ack = 0;
    end
    repeat (3) align();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_squash();
    test_reset_in_req();
    test_timeout();
    test_spurious();
    test_back_to_back();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending writebacks, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
